pipe_stage_skid_reg: RTL

//  Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) for the 32-bit MIPS core.

---
 rtl/pipe_stage_skid_reg.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Generic inter-stage pipeline register with a valid/ready handshake.
// It has a main entry that drives the outputs and a skid entry that holds one
// extra instruction, so in_ready depends only on a register. A synchronous
// FLUSH inserts a bubble, and a saturating counter records back-pressure cycles.
module pipe_stage_skid_reg #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 116,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic             CLR_DATA_P = (CLEAR_DATA != 0);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    // Data value an entry keeps when it becomes empty: zero or the old contents.
    function automatic logic [DATA_W-1:0] drain_data(input logic [DATA_W-1:0] d);
        drain_data = CLR_DATA_P ? {DATA_W{1'b0}} : d;
    endfunction

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic              in_fire_s;
    logic              out_fire_s;

    assign in_ready   = ~skid_valid_q;
    assign out_valid  = main_valid_q;
    assign out_ctrl   = main_ctrl_q;
    assign out_data   = main_data_q;
    assign stall_cnt  = stall_cnt_q;
    assign in_fire_s  = in_valid & ~skid_valid_q;
    assign out_fire_s = main_valid_q & out_ready;

    // Next state of the two entries. A flush wins over every transfer in the same cycle.
    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (FLUSH) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = {CTRL_W{1'b0}};
            main_data_d  = drain_data(main_data_q);
            skid_valid_d = 1'b0;
            skid_ctrl_d  = {CTRL_W{1'b0}};
            skid_data_d  = drain_data(skid_data_q);
        end else begin
            case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    if (in_fire_s) begin
                        main_valid_d = 1'b1;
                        main_ctrl_d  = in_ctrl;
                        main_data_d  = in_data;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end
                2'b10: begin
                    if (in_fire_s && out_fire_s) begin
                        main_ctrl_d  = in_ctrl;
                        main_data_d  = in_data;
                    end else if (in_fire_s) begin
                        skid_valid_d = 1'b1;
                        skid_ctrl_d  = in_ctrl;
                        skid_data_d  = in_data;
                    end else if (out_fire_s) begin
                        main_valid_d = 1'b0;
                        main_ctrl_d  = {CTRL_W{1'b0}};
                        main_data_d  = drain_data(main_data_q);
                    end else begin
                        main_valid_d = 1'b1;
                    end
                end
                2'b11: begin
                    // The skid entry is older than any new input, so it moves up first.
                    if (out_fire_s) begin
                        main_ctrl_d  = skid_ctrl_q;
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                        skid_ctrl_d  = {CTRL_W{1'b0}};
                        skid_data_d  = {DATA_W{1'b0}};
                    end else begin
                        skid_valid_d = 1'b1;
                    end
                end
                default: begin
                    // A skid entry without a main entry is unreachable. Recover to empty.
                    main_valid_d = 1'b0;
                    main_ctrl_d  = {CTRL_W{1'b0}};
                    main_data_d  = {DATA_W{1'b0}};
                    skid_valid_d = 1'b0;
                    skid_ctrl_d  = {CTRL_W{1'b0}};
                    skid_data_d  = {DATA_W{1'b0}};
                end
            endcase
        end
    end

    // Saturating back-pressure counter. A clear wins over an increment, and FLUSH has no effect.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (main_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= {CTRL_W{1'b0}};
            main_data_q  <= {DATA_W{1'b0}};
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= {CTRL_W{1'b0}};
            skid_data_q  <= {DATA_W{1'b0}};
            stall_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule
